// File: rtl/ride_dispatcher.sv
// ride_dispatcher: issues the hold-then-release drive command when a full
// ride load is waiting, times the ride, and shows the dispatch count.
module ride_dispatcher #(
   parameter int unsigned HOLD_CYCLES   = 1024,
   parameter int unsigned SETTLE_CYCLES = 4,
   parameter int unsigned RIDE_CYCLES   = 50_000_000,
   parameter int unsigned RIDE_SIZE     = 8
) (
   input  logic       CLOCK_50,
   input  logic       rst,
   input  logic       enable,
   input  logic [4:0] wait_cnt,
   output logic       drive_out,
   output logic       busy,
   output logic [3:0] ride_digit,
   output logic [0:6] HEX2
);

   typedef enum logic [1:0] {
      IDLE,
      ASSERT,
      RELEASE,
      RIDE
   } state_t;

   localparam logic [31:0] HOLD_TC   = 32'(HOLD_CYCLES - 1);
   localparam logic [31:0] SETTLE_TC = 32'(SETTLE_CYCLES - 1);
   localparam logic [31:0] RIDE_TC   = 32'(RIDE_CYCLES - 1);
   localparam logic [31:0] SIZE_W    = 32'(RIDE_SIZE);

   state_t      state_q, state_d;
   logic [31:0] timer_q, timer_d;
   logic [3:0]  digit_q, digit_d;
   logic        drive_q;
   logic        busy_q;
   logic [0:6]  hex_q;
   logic        go;

   // Active-low a..g pattern for one BCD digit; non-BCD blanks the display.
   function automatic logic [6:0] seg7(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'b000_0001;
         4'd1:    s = 7'b100_1111;
         4'd2:    s = 7'b001_0010;
         4'd3:    s = 7'b000_0110;
         4'd4:    s = 7'b100_1100;
         4'd5:    s = 7'b010_0100;
         4'd6:    s = 7'b010_0000;
         4'd7:    s = 7'b000_1111;
         4'd8:    s = 7'b000_0000;
         4'd9:    s = 7'b000_1100;
         default: s = 7'b111_1111;
      endcase
      return s;
   endfunction

   assign go = enable && ({27'd0, wait_cnt} >= SIZE_W);

   // Next state, shared timer and dispatch counter.
   always_comb begin
      state_d = state_q;
      timer_d = timer_q + 32'd1;
      digit_d = digit_q;
      unique case (state_q)
         IDLE: begin
            timer_d = '0;
            if (go) state_d = ASSERT;
         end
         ASSERT: begin
            if (timer_q == HOLD_TC) begin
               state_d = RELEASE;
               timer_d = '0;
            end
         end
         RELEASE: begin
            if (timer_q == SETTLE_TC) begin
               state_d = RIDE;
               timer_d = '0;
               digit_d = (digit_q == 4'd9) ? 4'd0
                                           : digit_q + 4'd1;
            end
         end
         RIDE: begin
            if (timer_q == RIDE_TC) begin
               state_d = IDLE;
               timer_d = '0;
            end
         end
         default: begin
            state_d = IDLE;
            timer_d = '0;
         end
      endcase
   end

   // State, timer and registered outputs derived from the next state.
   always_ff @(posedge CLOCK_50) begin
      if (rst) begin
         state_q <= IDLE;
         timer_q <= '0;
         digit_q <= '0;
         drive_q <= 1'b0;
         busy_q  <= 1'b0;
         hex_q   <= 7'b000_0001;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         digit_q <= digit_d;
         drive_q <= (state_d == ASSERT);
         busy_q  <= (state_d != IDLE);
         hex_q   <= seg7(digit_d);
      end
   end

   assign drive_out  = drive_q;
   assign busy       = busy_q;
   assign ride_digit = digit_q;
   assign HEX2       = hex_q;

endmodule

// File: tb/tb_ride_dispatcher.sv
// tb_ride_dispatcher: directed and random stimulus against a
// dispatch-timeline model of the ride dispatcher.
module tb_ride_dispatcher;

   localparam int HOLD   = 8;
   localparam int SETTLE = 2;
   localparam int RIDE   = 5;
   localparam int SIZE   = 8;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       enable = 1'b0;
   logic [4:0] wait_cnt = 5'd0;
   logic       drive_out;
   logic       busy;
   logic [3:0] ride_digit;
   logic [0:6] HEX2;

   always #5 clk = ~clk;

   ride_dispatcher #(
      .HOLD_CYCLES  (HOLD),
      .SETTLE_CYCLES(SETTLE),
      .RIDE_CYCLES  (RIDE),
      .RIDE_SIZE    (SIZE)
   ) dut (
      .CLOCK_50  (clk),
      .rst       (rst),
      .enable    (enable),
      .wait_cnt  (wait_cnt),
      .drive_out (drive_out),
      .busy      (busy),
      .ride_digit(ride_digit),
      .HEX2      (HEX2)
   );

   int vectors = 0;
   int miscompares = 0;

   // Model: m_t is the cycle index inside the current dispatch
   // (-1 when idle); m_count is completed dispatches mod 10.
   int m_t = -1;
   int m_count = 0;

   logic [6:0] seg_tab [10] = '{
      7'b000_0001, 7'b100_1111, 7'b001_0010, 7'b000_0110,
      7'b100_1100, 7'b010_0100, 7'b010_0000, 7'b000_1111,
      7'b000_0000, 7'b000_1100
   };

   task automatic check(input string name,
                        input logic [31:0] act,
                        input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t",
                  name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      if (rst) begin
         m_t = -1;
         m_count = 0;
      end else if (m_t < 0) begin
         if (enable && int'(wait_cnt) >= SIZE) m_t = 0;
      end else begin
         m_t++;
         if (m_t == HOLD + SETTLE) m_count = (m_count + 1) % 10;
         if (m_t == HOLD + SETTLE + RIDE) m_t = -1;
      end
      @(negedge clk);
      check("drive_out", 32'(drive_out),
            32'(m_t >= 0 && m_t < HOLD));
      check("busy", 32'(busy), 32'(m_t >= 0));
      check("ride_digit", 32'(ride_digit), 32'(m_count));
      check("HEX2", 32'(HEX2), 32'(seg_tab[m_count]));
   endtask

   task automatic wait_idle(input string name);
      for (int i = 0; i < 60 && busy; i++) tick();
      check(name, 32'(busy), 32'd0);
   endtask

   int hi;
   int seen;
   int cyc;
   int rises[$];
   logic prev;

   initial begin
      // Reset with the dispatch condition already true.
      rst = 1'b1; enable = 1'b1; wait_cnt = 5'd20;
      tick(); tick();
      check("rst_hex", 32'(HEX2), 32'h01);
      check("rst_drive", 32'(drive_out), 32'd0);
      rst = 1'b0;
      tick();
      check("first_assert", 32'(drive_out), 32'd1);

      // Threshold: 7 never dispatches, 8 does.
      rst = 1'b1; tick(); rst = 1'b0;
      wait_cnt = 5'd7;
      seen = 0;
      repeat (100) begin
         tick();
         if (drive_out) seen = 1;
      end
      check("thresh_7_idle", 32'(seen), 32'd0);
      wait_cnt = 5'd8;
      tick();
      hi = 0;
      while (drive_out && hi < 50) begin
         hi++;
         tick();
      end
      check("hold_len", 32'(hi), 32'd8);
      check("digit_at_fall", 32'(ride_digit), 32'd0);
      wait_cnt = 5'd0;
      tick(); tick();
      check("digit_after_settle", 32'(ride_digit), 32'd1);
      check("hex_after_settle", 32'(HEX2), 32'h4F);
      wait_idle("idle_after_thresh");

      // Enable gating.
      enable = 1'b0; wait_cnt = 5'd12;
      seen = 0;
      repeat (30) begin
         tick();
         if (busy) seen = 1;
      end
      check("enable_low_idle", 32'(seen), 32'd0);
      enable = 1'b1;
      tick();
      enable = 1'b0;
      hi = 1;
      repeat (40) begin
         tick();
         if (drive_out) hi++;
      end
      check("gated_hold_len", 32'(hi), 32'd8);
      check("gated_digit", 32'(ride_digit), 32'd2);

      // Wrap: ten back-to-back dispatches from a fresh reset.
      rst = 1'b1; tick(); rst = 1'b0;
      enable = 1'b1; wait_cnt = 5'd15;
      prev = drive_out;
      for (cyc = 0; cyc < 200 && rises.size() < 10; cyc++) begin
         tick();
         if (drive_out && !prev) rises.push_back(cyc);
         prev = drive_out;
      end
      check("wrap_dispatches", 32'(rises.size()), 32'd10);
      for (int i = 1; i < rises.size(); i++)
         check("period", 32'(rises[i] - rises[i-1]), 32'd16);
      enable = 1'b0;
      wait_idle("idle_after_wrap");
      check("wrap_digit", 32'(ride_digit), 32'd0);
      check("wrap_hex", 32'(HEX2), 32'h01);

      // Reset during the fourth drive cycle.
      enable = 1'b1; wait_cnt = 5'd9;
      tick();
      check("mid_rise", 32'(drive_out), 32'd1);
      tick(); tick(); tick();
      rst = 1'b1; enable = 1'b0;
      tick();
      check("mid_rst_drive", 32'(drive_out), 32'd0);
      check("mid_rst_digit", 32'(ride_digit), 32'd0);
      rst = 1'b0; enable = 1'b1;
      tick();
      enable = 1'b0;
      hi = 0;
      while (drive_out && hi < 50) begin
         hi++;
         tick();
      end
      check("restart_hold_len", 32'(hi), 32'd8);
      wait_idle("idle_after_restart");

      // Random traffic against the model.
      repeat (4000) begin
         rst = ($urandom_range(0, 199) == 0);
         enable = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 7) == 0)
            wait_cnt = 5'($urandom_range(0, 31));
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/ride_dispatcher.md
# ride_dispatcher

Drive-side controller for the amusement-park queue. It watches the queue's waiting count and, when a full ride load is waiting, issues the "drive (-8)" command. The command uses the same hold-then-release switch protocol that the queue's pulse generator qualifies: a level held past its threshold, then released. After issuing the command, the block times the ride run, counts completed dispatches and shows the count on one 7-segment digit.

## Interface
Parameters:
- HOLD_CYCLES, 1024: cycles `drive_out` is held high per command; must exceed the receiver threshold of 1000.
- SETTLE_CYCLES, 4: low cycles after release so the queue count can update before the ride timer starts.
- RIDE_CYCLES, 50_000_000: ride run time in clocks (1 s at 50 MHz).
- RIDE_SIZE, 8: people consumed per dispatch; dispatch threshold.

Ports:
- CLOCK_50  input  1  system clock; the only clock.
- rst  input  1  reset, synchronous, active-high.
- enable  input  1  dispatch permitted; sampled in IDLE only.
- wait_cnt  input  5  current waiting count, unsigned 0..20, synchronous to CLOCK_50.
- drive_out  output  1  drive command level; connects where SW[3] would feed the pulse generator.
- busy  output  1  high in every state except IDLE.
- ride_digit  output  4  dispatch count modulo 10, BCD.
- HEX2  output  [0:6]  active-low segments a..g showing `ride_digit`.

## Operation
- All outputs are registered. Reset values: `drive_out`=0, `busy`=0, `ride_digit`=0, HEX2=7'b000_0001 (digit 0). The state machine resets to IDLE and all timers to 0.
- FSM states are IDLE, ASSERT, RELEASE, RIDE.
- IDLE: if `enable` and `wait_cnt` >= RIDE_SIZE, go to ASSERT. Otherwise stay in IDLE.
- ASSERT: `drive_out`=1. The timer counts 0..HOLD_CYCLES-1. On terminal count, clear the timer and go to RELEASE.
- RELEASE: `drive_out`=0. The timer counts SETTLE_CYCLES cycles, then goes to RIDE. On the RELEASE→RIDE transition, `ride_digit` increments, wrapping 9→0.
- RIDE: `drive_out`=0. The timer counts RIDE_CYCLES cycles, then goes to IDLE.
- `enable` or `wait_cnt` changing outside IDLE has no effect; the current cycle always completes.
- `wait_cnt` > 20 is out of range but follows the same compare rule; it is not flagged.
- A single 32-bit timer is shared by all states. It is cleared on every state transition and never wraps, since every parameter is below 2^32.
- HEX2 encoding, active-low, a..g:
  - 0=000_0001, 1=100_1111, 2=001_0010, 3=000_0110, 4=100_1100
  - 5=010_0100, 6=010_0000, 7=000_1111, 8=000_0000, 9=000_1100
  - Any non-BCD value gives 111_1111 (blank). HEX2 is registered from the next `ride_digit` value, so it changes on the same edge as `ride_digit`.
- Reset mid-operation: at the next edge the block enters IDLE and `drive_out`=0. No partial command is counted. A truncated high level is harmless because the receiver is reset by the same `rst`.

## Timing
- Condition true in IDLE at edge N → state=ASSERT and `drive_out`=1 after edge N+1. Latency is 1 cycle.
- `drive_out` is high for exactly HOLD_CYCLES consecutive cycles per dispatch, then low for at least SETTLE_CYCLES+RIDE_CYCLES+1 cycles before it can rise again.
- `busy` rises on the same edge as `drive_out` rises. It falls on the edge that enters IDLE.
- `ride_digit` updates exactly SETTLE_CYCLES cycles after `drive_out` falls.
- Dispatch period with the condition held continuously: HOLD_CYCLES + SETTLE_CYCLES + RIDE_CYCLES + 1 cycles, where the +1 is the IDLE decision cycle.
- Back-to-back: if the condition is still true on the first IDLE cycle, the next ASSERT starts the following cycle.

## Test plan
Use HOLD_CYCLES=8, SETTLE_CYCLES=2, RIDE_CYCLES=5 unless stated otherwise.
- Reset: assert `rst` 2 cycles with `enable`=1, `wait_cnt`=20 → during reset `drive_out`=0, `busy`=0, `ride_digit`=0, HEX2=000_0001; first ASSERT begins 1 cycle after `rst` falls.
- Threshold: `wait_cnt`=7 held with `enable`=1 → no dispatch for 100 cycles. Step to 8 → `drive_out` high exactly 8 cycles; `ride_digit` becomes 1 and HEX2=100_1111 two cycles after the fall.
- Enable gating: `wait_cnt`=12 with `enable`=0 → IDLE held. Drop `enable` during ASSERT → command completes at full 8 cycles, count increments, no second dispatch.
- Wrap: hold the condition for 10 dispatches → period 16 cycles each; `ride_digit` sequence 1..9,0; HEX2 matches the encoding list at every step.
- Reset mid-ASSERT at cycle 4 → `drive_out`=0 next edge, `ride_digit` unchanged from its pre-dispatch value, restart produces a full 8-cycle pulse.
- Integration with the default HOLD_CYCLES=1024 driving the queue's pulse generator → exactly one generator output pulse per dispatch, and the queue count drops by 8.
